// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
// Imported by the top and by the read-port mux.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int N_RD_DEF   = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } regfile_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One read mux: stored data, optional same-cycle write forwarding, and the
// hard-wired zero entry. Output is held at zero while the file is clearing.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] stored,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata
);

    logic is_zero_reg;

    assign is_zero_reg = (ZERO_REG != 0) && (raddr == '0);

    // Write enables arrive already gated by READY and the zero entry, so a
    // match here is always a write that will really land this edge.
    always_comb begin
        rdata = '0;
        if (ready && !is_zero_reg) begin
            rdata = stored;
            if ((BYPASS != 0) && wr1_en && (waddr1 == raddr)) begin
                rdata = wdata1;
            end else if ((BYPASS != 0) && wr0_en && (waddr0 == raddr)) begin
                rdata = wdata0;
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: two prioritised write ports, N_RD combinational
// read ports, and a clear sequencer that zeroes every entry after reset or on request.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_RD     = N_RD_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    output logic                     ready_o,
    input  logic                     we0_i,
    input  logic [ADDR_W-1:0]        waddr0_i,
    input  logic [DATA_W-1:0]        wdata0_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        waddr1_i,
    input  logic [DATA_W-1:0]        wdata1_i,
    input  logic [N_RD*ADDR_W-1:0]   raddr_i,
    output logic [N_RD*DATA_W-1:0]   rdata_o,
    output logic                     collision_o,
    output regfile_state_e           state_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    regfile_state_e    state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              collision_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic ready;
    logic wr0_en, wr1_en;
    logic zero_a0, zero_a1;

    assign ready   = (state_q == READY);
    assign zero_a0 = (ZERO_REG != 0) && (waddr0_i == '0);
    assign zero_a1 = (ZERO_REG != 0) && (waddr1_i == '0);
    assign wr0_en  = ready && we0_i && !zero_a0;
    assign wr1_en  = ready && we1_i && !zero_a1;

    // Clear sequencer: one entry per cycle, leaves READY with pointer back at 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Port 1 is written last so it wins when both ports hit the same entry.
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR) begin
            mem[ptr_q] <= '0;
        end else begin
            if (wr0_en) begin
                mem[waddr0_i] <= wdata0_i;
            end
            if (wr1_en) begin
                mem[waddr1_i] <= wdata1_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= wr0_en && wr1_en && (waddr0_i == waddr1_i);
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] raddr_k;
        logic [DATA_W-1:0] stored_k;

        assign raddr_k  = raddr_i[k*ADDR_W +: ADDR_W];
        assign stored_k = mem[raddr_k];

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .ready  (ready),
            .raddr  (raddr_k),
            .stored (stored_k),
            .wr0_en (wr0_en),
            .waddr0 (waddr0_i),
            .wdata0 (wdata0_i),
            .wr1_en (wr1_en),
            .waddr1 (waddr1_i),
            .wdata1 (wdata1_i),
            .rdata  (rdata_o[k*DATA_W +: DATA_W])
        );
    end

    assign ready_o     = ready;
    assign collision_o = collision_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: one bypassing and one non-bypassing file share all stimulus;
// expected values are hand-derived constants plus a queue for the fill readback.
module tb_regfile_multiport;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          clear_i = 1'b0;
    logic          we0_i = 1'b0, we1_i = 1'b0;
    logic [AW-1:0] waddr0_i = '0, waddr1_i = '0;
    logic [DW-1:0] wdata0_i = '0, wdata1_i = '0;
    logic [NR*AW-1:0] raddr_i = '0;

    logic              ready_b, ready_nb, coll_b, coll_nb;
    logic [NR*DW-1:0]  rdata_b, rdata_nb;
    regfile_state_e    state_b, state_nb;

    int n_vec  = 0;
    int n_miss = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .ready_o(ready_b),
        .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
        .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i),
        .raddr_i(raddr_i), .rdata_o(rdata_b), .collision_o(coll_b), .state_o(state_b)
    );

    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .ready_o(ready_nb),
        .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
        .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i),
        .raddr_i(raddr_i), .rdata_o(rdata_nb), .collision_o(coll_nb), .state_o(state_nb)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_b(input int k);
        return rdata_b[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rd_nb(input int k);
        return rdata_nb[k*DW +: DW];
    endfunction

    task automatic set_raddr(input int k, input logic [AW-1:0] a);
        raddr_i[k*AW +: AW] = a;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_writes();
        we0_i = 1'b0;
        we1_i = 1'b0;
    endtask

    // Count edges until both files report ready; bounded.
    task automatic count_to_ready(input string tag, input int exp_cycles);
        int cnt = 0;
        while (!(ready_b && ready_nb) && cnt < 100) begin
            tick();
            cnt++;
        end
        check(tag, DW'(cnt), DW'(exp_cycles));
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            set_raddr(0, AW'(a));
            set_raddr(1, AW'(DEPTH - 1 - a));
            #1;
            check({tag, "_b0"}, rd_b(0), '0);
            check({tag, "_b1"}, rd_b(1), '0);
            check({tag, "_nb0"}, rd_nb(0), '0);
            check({tag, "_nb1"}, rd_nb(1), '0);
        end
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_ready_b", DW'(ready_b), '0);
        check("rst_ready_nb", DW'(ready_nb), '0);
        check("rst_coll", DW'(coll_b | coll_nb), '0);
        check("rst_rdata", rdata_b | rdata_nb, '0);
        tick();
        tick();
        rst_i = 1'b0;
        count_to_ready("post_rst_clear_cycles", DEPTH);
        check_all_zero("init_zero");

        // Port 0 write: bypass visible same cycle, stored visible next cycle.
        tick();
        we0_i = 1'b1; waddr0_i = 5'd5; wdata0_i = 32'hDEADBEEF;
        set_raddr(0, 5'd5); set_raddr(1, 5'd6);
        #1;
        check("byp_same_b", rd_b(0), 32'hDEADBEEF);
        check("byp_same_nb", rd_nb(0), 32'h0);
        check("byp_other_port", rd_b(1), 32'h0);
        tick();
        idle_writes();
        #1;
        check("wr_next_b", rd_b(0), 32'hDEADBEEF);
        check("wr_next_nb", rd_nb(0), 32'hDEADBEEF);
        check("no_coll_single", DW'(coll_b), '0);

        // Same-address collision on x7.
        we0_i = 1'b1; waddr0_i = 5'd7; wdata0_i = 32'h1111;
        we1_i = 1'b1; waddr1_i = 5'd7; wdata1_i = 32'h2222;
        set_raddr(0, 5'd7); set_raddr(1, 5'd7);
        #1;
        check("coll_byp_b", rd_b(1), 32'h2222);
        check("coll_byp_nb", rd_nb(1), 32'h0);
        check("coll_before_edge", DW'(coll_b), '0);
        tick();
        idle_writes();
        #1;
        check("coll_pulse_b", DW'(coll_b), 1);
        check("coll_pulse_nb", DW'(coll_nb), 1);
        check("coll_data_b", rd_b(0), 32'h2222);
        check("coll_data_nb", rd_nb(0), 32'h2222);
        tick();
        check("coll_one_cycle", DW'(coll_b), '0);

        // Distinct addresses on both ports: both land, no collision.
        we0_i = 1'b1; waddr0_i = 5'd9;  wdata0_i = 32'hA5A5_0009;
        we1_i = 1'b1; waddr1_i = 5'd10; wdata1_i = 32'h5A5A_000A;
        tick();
        idle_writes();
        set_raddr(0, 5'd9); set_raddr(1, 5'd10);
        #1;
        check("dual_p0", rd_nb(0), 32'hA5A5_0009);
        check("dual_p1", rd_nb(1), 32'h5A5A_000A);
        check("dual_no_coll", DW'(coll_b), '0);

        // Writes to x0 on both ports are discarded and never collide.
        we0_i = 1'b1; waddr0_i = 5'd0; wdata0_i = 32'hFFFFFFFF;
        we1_i = 1'b1; waddr1_i = 5'd0; wdata1_i = 32'hFFFFFFFF;
        set_raddr(0, 5'd0); set_raddr(1, 5'd0);
        #1;
        check("x0_same_b", rd_b(0), '0);
        check("x0_same_nb", rd_nb(1), '0);
        tick();
        idle_writes();
        #1;
        check("x0_next_b", rd_b(0), '0);
        check("x0_next_nb", rd_nb(0), '0);
        check("x0_no_coll", DW'(coll_b | coll_nb), '0);

        // Fill x1..x31 with their index, port 1 on odd entries.
        for (int a = 1; a < DEPTH; a++) begin
            if (a % 2 == 1) begin
                we1_i = 1'b1; waddr1_i = AW'(a); wdata1_i = DW'(a);
                we0_i = 1'b0;
            end else begin
                we0_i = 1'b1; waddr0_i = AW'(a); wdata0_i = DW'(a);
                we1_i = 1'b0;
            end
            exp_q.push_back(DW'(a));
            tick();
        end
        idle_writes();
        for (int a = 1; a < DEPTH; a++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            set_raddr(0, AW'(a));
            #1;
            check("fill_rb_b", rd_b(0), e);
            check("fill_rb_nb", rd_nb(0), e);
        end

        // Clear request with a write in the same cycle; writes keep coming during clear.
        clear_i = 1'b1;
        we0_i = 1'b1; waddr0_i = 5'd3; wdata0_i = 32'h0000ABCD;
        tick();
        clear_i = 1'b0;
        check("clr_ready_drop", DW'(ready_b | ready_nb), '0);
        set_raddr(0, 5'd20);
        #1;
        check("clr_rdata_forced", rd_b(0) | rd_nb(0), '0);
        begin
            int cnt = 0;
            while (!(ready_b && ready_nb) && cnt < 100) begin
                we0_i = 1'b1; waddr0_i = AW'(cnt);      wdata0_i = 32'hBAD0_0000 | DW'(cnt);
                we1_i = 1'b1; waddr1_i = AW'(31 - cnt); wdata1_i = 32'hBAD1_0000 | DW'(cnt);
                if (cnt == 5) clear_i = 1'b1;
                tick();
                cnt++;
                check("clr_no_coll", DW'(coll_b), '0);
            end
            idle_writes();
            clear_i = 1'b0;
            check("clear_cycles", DW'(cnt), DEPTH);
        end
        check_all_zero("after_clear");

        // Reset from READY with a collision pulse pending.
        we0_i = 1'b1; waddr0_i = 5'd12; wdata0_i = 32'h1;
        we1_i = 1'b1; waddr1_i = 5'd12; wdata1_i = 32'h2;
        tick();
        idle_writes();
        set_raddr(0, 5'd12);
        check("pre_rst_coll", DW'(coll_b), 1);
        rst_i = 1'b1;
        #1;
        check("async_rst_ready", DW'(ready_b | ready_nb), '0);
        check("async_rst_coll", DW'(coll_b | coll_nb), '0);
        check("async_rst_rdata", rd_b(0) | rd_nb(0), '0);
        tick();
        rst_i = 1'b0;
        count_to_ready("rst_ready_cycles", DEPTH);

        // Reset in the middle of a clear restarts the sequence from entry 0.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        repeat (10) tick();
        check("midclr_state", DW'(state_b), DW'(CLEAR));
        #2;
        rst_i = 1'b1;
        #1;
        check("midclr_rst_ready", DW'(ready_b), '0);
        tick();
        tick();
        rst_i = 1'b0;
        count_to_ready("midclr_restart_cycles", DEPTH);
        check_all_zero("midclr_zero");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the 32x32 register file: configurable data width, depth and read-port count, two write ports with fixed priority, optional write-to-read bypass, and a hardware clear sequencer that zeroes every entry after reset or on request. Sits in the core's decode/writeback stage; the second write port serves a load/long-latency writeback path alongside the ALU writeback.

## Interface
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  request full clear (sampled only in READY)
- ready_o  out  1  1 = file usable; 0 during clear sequence
- we0_i  in  1  write enable, port 0 (ALU writeback)
- waddr0_i  in  ADDR_W  write address, port 0
- wdata0_i  in  DATA_W  write data, port 0
- we1_i  in  1  write enable, port 1 (priority port)
- waddr1_i  in  ADDR_W  write address, port 1
- wdata1_i  in  DATA_W  write data, port 1
- raddr_i  in  N_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rdata_o  out  N_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
- collision_o  out  1  registered pulse: both ports wrote the same address last cycle

## Operation
- FSM states CLEAR, READY. Reset value: state CLEAR, clear pointer 0, ready_o 0, collision_o 0, rdata_o 0.
- CLEAR: each cycle write 0 to entry [pointer], pointer += 1; when pointer == DEPTH-1 the write completes and state becomes READY on the next edge. Pointer wraps to 0 on exit.
- READY: clear_i = 1 -> CLEAR next edge, pointer 0. clear_i in CLEAR is ignored (no restart).
- In CLEAR: we0_i/we1_i ignored; all rdata_o forced 0; collision_o held 0.
- Writes (READY only): each enabled port writes its entry on the rising edge. Both enabled, same address: port 1 data stored, port 0 dropped, collision_o = 1 in the following cycle (one-cycle pulse, rearms each cycle). Same address and ZERO_REG=1 and address 0: no collision flagged.
- ZERO_REG=1: writes to address 0 discarded; any read of address 0 returns 0 regardless of bypass.
- Reads: combinational from stored array. BYPASS=1: if read address equals an enabled write address this cycle (and is not a zeroed address 0), return that write data, port 1 over port 0. BYPASS=0: return stored (pre-write) value.
- Read ports independent; any ports may share an address.

## Timing
- Read latency: 0 cycles (combinational address-to-data).
- Write-to-read: visible same cycle with BYPASS=1, next cycle with BYPASS=0.
- Clear duration: exactly DEPTH cycles from first clock edge after rst_i deasserts (or after clear_i sampled) to ready_o = 1; DEPTH+1 edges including the request edge for clear_i.
- rst_i assertion mid-operation: ready_o, collision_o, rdata_o go 0 immediately (asynchronously); array contents undefined until clear completes.
- clear_i and write in the same READY cycle: write performed, then clear starts; the written value is erased by the sequence.
- collision_o: asserted exactly one cycle after the colliding edge.

## Structure
- Package regfile_pkg: state enum typedef (CLEAR, READY), default parameter constants (DATA_W, ADDR_W, N_RD).
- Sub-module regfile_read_port: one read mux with zero-register and bypass logic, instantiated N_RD times via generate.
- Array, write-priority logic, clear FSM and collision flag in the top module.

## Test plan
- Reset, release, count cycles -> ready_o rises after exactly 32 cycles (ADDR_W=5); all reads of addresses 0..31 return 0.
- READY, write 0xDEADBEEF to x5 via port 0, read port 0 addr 5 same cycle -> 0xDEADBEEF with BYPASS=1, old value 0 with BYPASS=0; next cycle 0xDEADBEEF both builds.
- Both ports write addr 7 (port0 0x1111, port1 0x2222) -> next cycle read x7 = 0x2222, collision_o = 1 for one cycle only.
- Write 0xFFFFFFFF to x0 on both ports -> read x0 = 0 same and next cycle, collision_o stays 0.
- Fill x1..x31 with index values, pulse clear_i -> ready_o 0 for 32 cycles, writes during that window ignored, afterwards all reads 0.
- Assert rst_i mid-clear (pointer ~10) -> ready_o 0 immediately, sequence restarts from 0 and completes 32 cycles after release.
